// File: rtl/rr_arbiter_3ch.sv
// Registered three-channel round-robin arbiter feeding a zero-default 3-to-1 select mux.
// One beat per cycle is captured into data_out/select; idle output reads select=00, data_out=0.
module rr_arbiter_3ch #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   valid,
   input  logic [W-1:0] ch_0,
   input  logic [W-1:0] ch_1,
   input  logic [W-1:0] ch_2,
   output logic [2:0]   ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] data_out,
   output logic [1:0]   select
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t       state;
   state_t       state_next;
   logic [1:0]   ptr;
   logic [1:0]   win;
   logic         hit;
   logic         free;
   logic         xfer;
   logic [W-1:0] win_data;

   // Priority search starting at ptr and wrapping mod 3.
   always_comb begin
      hit = 1'b1;
      win = 2'd0;
      case (ptr)
         2'd1: begin
            if (valid[1])      win = 2'd1;
            else if (valid[2]) win = 2'd2;
            else if (valid[0]) win = 2'd0;
            else               hit = 1'b0;
         end
         2'd2: begin
            if (valid[2])      win = 2'd2;
            else if (valid[0]) win = 2'd0;
            else if (valid[1]) win = 2'd1;
            else               hit = 1'b0;
         end
         default: begin
            if (valid[0])      win = 2'd0;
            else if (valid[1]) win = 2'd1;
            else if (valid[2]) win = 2'd2;
            else               hit = 1'b0;
         end
      endcase
   end

   assign free      = (state == EMPTY) || out_ready;
   // rst gates ready so no handshake is offered while the block is held in reset.
   assign xfer      = hit && free && !rst;
   assign out_valid = (state == FULL);

   always_comb begin
      ready    = 3'b000;
      win_data = ch_0;
      case (win)
         2'd1: begin
            win_data = ch_1;
            if (xfer) ready = 3'b010;
         end
         2'd2: begin
            win_data = ch_2;
            if (xfer) ready = 3'b100;
         end
         default: begin
            win_data = ch_0;
            if (xfer) ready = 3'b001;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      if (xfer)
         state_next = FULL;
      else if ((state == FULL) && out_ready)
         state_next = EMPTY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_next;
   end

   // A reload in the same cycle as a drain takes priority, keeping back-to-back throughput.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         select   <= 2'b00;
         ptr      <= 2'd0;
      end else if (xfer) begin
         data_out <= win_data;
         select   <= win + 2'd1;
         ptr      <= (win == 2'd2) ? 2'd0 : win + 2'd1;
      end else if ((state == FULL) && out_ready) begin
         data_out <= '0;
         select   <= 2'b00;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_3ch.sv
// Directed bench for rr_arbiter_3ch: vector table walked cycle by cycle, plus a
// hand-written asynchronous reset sequence.
module tb_rr_arbiter_3ch;

   localparam logic [31:0] A = 32'hAAAA_0000;
   localparam logic [31:0] B = 32'hBBBB_1111;
   localparam logic [31:0] C = 32'hCCCC_2222;
   localparam logic [31:0] D = 32'h0F0F_0F0F;
   localparam logic [31:0] P = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  valid;
   logic [31:0] ch_0, ch_1, ch_2;
   logic [2:0]  ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic [1:0]  select;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  valid;
      logic [31:0] c0, c1, c2;
      logic        ordy;
      logic [2:0]  exp_ready;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   rr_arbiter_3ch #(.W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .ch_0      (ch_0),
      .ch_1      (ch_1),
      .ch_2      (ch_2),
      .ready     (ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .select    (select)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [2:0] v, input logic [31:0] c0, input logic [31:0] c1,
                      input logic [31:0] c2, input logic ordy, input logic [2:0] er,
                      input logic eov, input logic [1:0] esel, input logic [31:0] ed);
      vec_t r;
      r.valid = v; r.c0 = c0; r.c1 = c1; r.c2 = c2; r.ordy = ordy;
      r.exp_ready = er; r.exp_ov = eov; r.exp_sel = esel; r.exp_data = ed;
      vecs.push_back(r);
   endtask

   initial begin
      // Each row: inputs applied before an edge; expected ready (combinational) and
      // expected registered outputs as they stand before that edge.
      //   valid   ch_0 ch_1 ch_2 ordy ready   ov  sel    data
      add(3'b000, A, B, C, 1'b1, 3'b000, 1'b0, 2'b00, 32'h0);  // idle after reset
      add(3'b111, A, B, C, 1'b1, 3'b001, 1'b0, 2'b00, 32'h0);  // rotation starts at ch_0
      add(3'b111, A, B, C, 1'b1, 3'b010, 1'b1, 2'b01, A);
      add(3'b111, A, B, C, 1'b1, 3'b100, 1'b1, 2'b10, B);
      add(3'b111, A, B, C, 1'b1, 3'b001, 1'b1, 2'b11, C);
      add(3'b000, A, B, C, 1'b1, 3'b000, 1'b1, 2'b01, A);      // drain
      add(3'b000, A, B, C, 1'b1, 3'b000, 1'b0, 2'b00, 32'h0);
      add(3'b010, A, P, C, 1'b1, 3'b010, 1'b0, 2'b00, 32'h0);  // single ch_1
      add(3'b000, A, P, C, 1'b1, 3'b000, 1'b1, 2'b10, P);
      add(3'b000, A, P, C, 1'b1, 3'b000, 1'b0, 2'b00, 32'h0);
      add(3'b100, A, B, C, 1'b1, 3'b100, 1'b0, 2'b00, 32'h0);  // ch_2 beat, ptr -> 0
      add(3'b111, A, B, C, 1'b0, 3'b000, 1'b1, 2'b11, C);      // backpressure x4
      add(3'b111, A, B, C, 1'b0, 3'b000, 1'b1, 2'b11, C);
      add(3'b111, A, B, C, 1'b0, 3'b000, 1'b1, 2'b11, C);
      add(3'b111, A, B, C, 1'b0, 3'b000, 1'b1, 2'b11, C);
      add(3'b111, A, B, C, 1'b1, 3'b001, 1'b1, 2'b11, C);      // release: ch_0 with drain
      add(3'b101, A, B, C, 1'b1, 3'b100, 1'b1, 2'b01, A);      // pointer skip to ch_2
      add(3'b101, A, B, C, 1'b1, 3'b001, 1'b1, 2'b11, C);      // then back to ch_0
      add(3'b001, D, B, C, 1'b1, 3'b001, 1'b1, 2'b01, A);      // drain and reload
      add(3'b000, D, B, C, 1'b1, 3'b000, 1'b1, 2'b01, D);
      add(3'b000, D, B, C, 1'b1, 3'b000, 1'b0, 2'b00, 32'h0);
      add(3'b010, A, B, C, 1'b0, 3'b010, 1'b0, 2'b00, 32'h0);  // empty slot ignores out_ready
      add(3'b000, A, B, C, 1'b0, 3'b000, 1'b1, 2'b10, B);
      add(3'b001, A, B, C, 1'b0, 3'b000, 1'b1, 2'b10, B);      // held: no grant
      add(3'b001, A, B, C, 1'b1, 3'b001, 1'b1, 2'b10, B);      // ptr=2 wraps to ch_0
      add(3'b000, A, B, C, 1'b0, 3'b000, 1'b1, 2'b01, A);

      rst = 1'b1; valid = 3'b000; ch_0 = '0; ch_1 = '0; ch_2 = '0; out_ready = 1'b0;
      #2;
      check("reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("reset_select",    {30'h0, select},    32'h0);
      check("reset_data",      data_out,           32'h0);
      check("reset_ready",     {29'h0, ready},     32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         valid = vecs[i].valid; ch_0 = vecs[i].c0; ch_1 = vecs[i].c1; ch_2 = vecs[i].c2;
         out_ready = vecs[i].ordy;
         #1;
         check($sformatf("v%0d_ready", i),     {29'h0, ready},     {29'h0, vecs[i].exp_ready});
         check($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_ov});
         check($sformatf("v%0d_select", i),    {30'h0, select},    {30'h0, vecs[i].exp_sel});
         check($sformatf("v%0d_data", i),      data_out,           vecs[i].exp_data);
         @(negedge clk);
      end

      // Mid-operation reset with a held beat; state before: FULL A, ptr=1.
      valid = 3'b001; ch_0 = 32'hDEAD_BEEF; out_ready = 1'b1;
      #1;
      check("mr_load_ready", {29'h0, ready}, 32'h1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      #1;
      check("mr_held_valid", {31'h0, out_valid}, 32'h1);
      check("mr_held_data",  data_out,           32'hDEAD_BEEF);
      rst = 1'b1;
      #1;
      check("mr_out_valid", {31'h0, out_valid}, 32'h0);
      check("mr_select",    {30'h0, select},    32'h0);
      check("mr_data",      data_out,           32'h0);
      check("mr_ready",     {29'h0, ready},     32'h0);
      @(negedge clk);
      rst = 1'b0;
      valid = 3'b111; ch_0 = A; ch_1 = B; ch_2 = C; out_ready = 1'b1;
      #1;
      check("mr_first_grant", {29'h0, ready}, 32'h1);
      @(posedge clk);
      #1;
      check("mr_post_valid",  {31'h0, out_valid}, 32'h1);
      check("mr_post_select", {30'h0, select},    32'h1);
      check("mr_post_data",   data_out,           A);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_3ch.md
# rr_arbiter_3ch

Registered three-channel round-robin arbiter that sits directly upstream of the datapath's 3-to-1 zero-default select mux. It accepts valid/ready handshakes on three W-bit operand channels and picks one per cycle. The chosen beat is captured into an output register, together with the 2-bit channel code in the mux's select encoding (00 = none/zero, 01 = ch_0, 10 = ch_1, 11 = ch_2). Downstream logic can consume data_out directly or drive the mux with select.

## Interface
- W, default 32, data width of each channel and of data_out.

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- valid  input  3  per-channel request; bit i belongs to ch_i
- ch_0  input  W  channel 0 data
- ch_1  input  W  channel 1 data
- ch_2  input  W  channel 2 data
- ready  output  3  per-channel accept; at most one bit high in any cycle
- out_valid  output  1  data_out/select hold an unconsumed beat
- out_ready  input  1  downstream accepts beat when high with out_valid
- data_out  output  W  registered winning channel data
- select  output  2  registered code of channel that produced data_out

## Operation
- State:
  - output register: data_out, select and out_valid;
  - round-robin pointer ptr in {0,1,2}.
- Slot free: `free = !out_valid || out_ready`.
- Arbitration (combinational):
  - Search order is ptr, ptr+1, ptr+2 (mod 3).
  - The winner is the first channel with its valid bit set.
  - ready[winner] = free. All other ready bits are 0.
  - If no valid bit is set, or free=0, then ready = 3'b000.
- Transfer on channel i: valid[i] && ready[i].
- On a transfer on channel i, at the next edge:
  - data_out ← ch_i;
  - select ← i+1 (01/10/11);
  - out_valid ← 1;
  - ptr ← (i+1) mod 3.
- Drain without reload (out_valid && out_ready, no input transfer): out_valid ← 0, select ← 00, data_out ← 0. An idle output therefore always reads 00 and zero, matching the mux's 00 encoding.
- Drain and reload in the same cycle: the reload wins. out_valid stays 1 and data_out/select take the new beat, giving back-to-back throughput.
- Held (out_valid && !out_ready): data_out, select and out_valid are stable. ready = 000 and ptr is unchanged.
- ptr advances only on a transfer, never on idle cycles.
- Output states:
  - EMPTY (out_valid=0): goes to FULL on a transfer.
  - FULL (out_valid=1): goes to EMPTY on a drain with no transfer; stays FULL on a drain with a transfer, or while held.

## Timing
- Reset values (asynchronous, take effect immediately while rst=1): out_valid=0, select=00, data_out=0, ptr=0, ready=000.
- Release of rst is synchronous to clk. ready may assert in the first cycle after release.
- Latency: 1 cycle from an input transfer edge to out_valid/data_out visible.
- Throughput: 1 beat/cycle when out_ready is held high.
- Combinational paths:
  - ready depends combinationally on valid, out_valid, out_ready and ptr.
  - data_out, select and out_valid are pure register outputs with no combinational path from any input.
- Fairness: with all three valid continuously asserted and out_ready=1, grants rotate 0,1,2,0,... A continuously requesting channel waits at most 2 grants.
- Reset mid-operation clears a held beat; it is lost, with no partial output. ptr returns to 0.
- Upstream must hold valid[i] and ch_i stable until ready[i]. The block does not check this.

## Test plan
- Reset: assert rst mid-cycle with out_valid=1, data_out=0xDEADBEEF -> outputs drop immediately to out_valid=0, select=00, data_out=0, ready=000; after release the first grant goes to ch_0.
- Single channel: valid=010, ch_1=0x12345678, out_ready=1 -> ready=010 for one cycle; next cycle out_valid=1, select=10, data_out=0x12345678; following idle cycle select=00, data_out=0.
- Full rotation: valid=111 held, ch_0=A, ch_1=B, ch_2=C, out_ready=1 -> select sequence 01,10,11,01,... with data A,B,C,A,... and out_valid continuously 1.
- Backpressure: beat from ch_2 captured, then out_ready=0 for 4 cycles with valid=111 -> select=11 and data_out stable, ready=000 throughout; on out_ready=1 the next grant is ch_0 (ptr=0) in the same cycle as the drain.
- Pointer skip: after a ch_0 grant, valid=101 -> ch_2 granted (select=11); then valid=101 again -> ch_0 granted (select=01).
- Drain and reload: out_valid=1, out_ready=1, valid=001 in the same cycle -> out_valid never drops, data_out changes to ch_0 data at the next edge.
